// File: rtl/uart_rx_host_ctrl.sv
// Host-side controller for the UART receiver: handshakes with the receiver,
// buffers captured words in a small FIFO and keeps saturating error counters.
module uart_rx_host_ctrl #(
    parameter int word_size      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_ADDR_BITS = 2,
    parameter int ERR_CNT_BITS   = 8
) (
    input  logic                      Sample_clk,
    input  logic                      rst_b,
    input  logic                      rx_enable,
    input  logic                      flush,
    input  logic                      clr_counts,
    input  logic [word_size-1:0]      RCV_datareg,
    input  logic                      load,
    input  logic                      read_not_ready_out,
    input  logic                      Error1,
    input  logic                      Error2,
    output logic                      read_not_ready_in,
    output logic [word_size-1:0]      host_data,
    output logic                      host_valid,
    input  logic                      host_ready,
    output logic [FIFO_ADDR_BITS:0]   fifo_count,
    output logic [ERR_CNT_BITS-1:0]   overrun_count,
    output logic [ERR_CNT_BITS-1:0]   framing_count
);

    typedef enum logic [0:0] {
        ST_WAIT    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    localparam logic [FIFO_ADDR_BITS+1:0] DEPTH_W = (FIFO_ADDR_BITS+2)'(FIFO_DEPTH);
    localparam logic [FIFO_ADDR_BITS:0]   DEPTH_C = (FIFO_ADDR_BITS+1)'(FIFO_DEPTH);

    state_t                    state_q, state_d;
    logic [word_size-1:0]      mem_q [FIFO_DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS:0]   count_q, count_d;
    logic                      rnr_q, rnr_d;
    logic [ERR_CNT_BITS-1:0]   ovr_q, ovr_d;
    logic [ERR_CNT_BITS-1:0]   frm_q, frm_d;
    logic                      push_s, pop_s;
    logic [FIFO_ADDR_BITS+1:0] occ_next_s;

    // A capture landing on a full FIFO is dropped; flush suppresses both push and pop.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (!flush) begin
            push_s = (state_q == ST_CAPTURE) && (count_q < DEPTH_C);
            pop_s  = (count_q != '0) && host_ready;
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Next-state for FSM, pointers, occupancy and the not-ready handshake.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            state_d  = ST_WAIT;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                ST_WAIT:    state_d = load ? ST_CAPTURE : ST_WAIT;
                ST_CAPTURE: state_d = ST_WAIT;
                default:    state_d = ST_WAIT;
            endcase
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {{FIFO_ADDR_BITS{1'b0}}, push_s}
                              - {{FIFO_ADDR_BITS{1'b0}}, pop_s};
        end
        // A pending capture already owns a slot, so it counts toward occupancy.
        occ_next_s = {1'b0, count_d} + {{(FIFO_ADDR_BITS+1){1'b0}}, (state_d == ST_CAPTURE)};
        rnr_d      = ~rx_enable | (occ_next_s >= DEPTH_W);
    end

    // Saturating error counters; clear wins over a same-cycle event.
    always_comb begin
        ovr_d = ovr_q;
        frm_d = frm_q;
        if (clr_counts) begin
            ovr_d = '0;
            frm_d = '0;
        end else begin
            if (Error1 && (ovr_q != '1)) begin
                ovr_d = ovr_q + 1'b1;
            end else begin
                ovr_d = ovr_q;
            end
            if (Error2 && (frm_q != '1)) begin
                frm_d = frm_q + 1'b1;
            end else begin
                frm_d = frm_q;
            end
        end
    end

    // Control state, handshake and counter registers.
    always_ff @(posedge Sample_clk or posedge rst_b) begin
        if (rst_b) begin
            state_q  <= ST_WAIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rnr_q    <= 1'b1;
            ovr_q    <= '0;
            frm_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rnr_q    <= rnr_d;
            ovr_q    <= ovr_d;
            frm_q    <= frm_d;
        end
    end

    // FIFO storage; cleared on reset so host_data reads zero afterwards.
    always_ff @(posedge Sample_clk or posedge rst_b) begin
        if (rst_b) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= RCV_datareg;
        end
    end

    assign read_not_ready_in = rnr_q;
    assign host_data         = mem_q[rd_ptr_q];
    assign host_valid        = (count_q != '0);
    assign fifo_count        = count_q;
    assign overrun_count     = ovr_q;
    assign framing_count     = frm_q;

    logic unused_s;
    assign unused_s = read_not_ready_out;

endmodule

// File: doc/uart_rx_host_ctrl.md
Name: uart_rx_host_ctrl

Overview:
Host-side controller for the UART receiver.
- Drives the receiver's read_not_ready_in handshake and captures each word the receiver loads into RCV_datareg.
- Buffers captured words in a FIFO_DEPTH-entry FIFO and presents them to the host on a valid/ready interface.
- Keeps saturating counters for overrun (Error1) and framing (Error2) events.
- Sits between the UART receiver's datapath/control outputs and the host bus.

Parameters:
- word_size, 8, width of received word and FIFO entries.
- FIFO_DEPTH, 4, number of FIFO entries (power of two).
- FIFO_ADDR_BITS, 2, log2(FIFO_DEPTH).
- ERR_CNT_BITS, 8, width of each error counter.

Ports:
- Sample_clk  in  1  sampling clock, shared with the receiver; all state updates on its rising edge.
- rst_b  in  1  asynchronous, active-high reset.
- rx_enable  in  1  1 = accept frames; 0 = hold receiver not-ready.
- flush  in  1  single-cycle pulse; empties FIFO and drops any pending capture.
- clr_counts  in  1  single-cycle pulse; zeroes both error counters.
- RCV_datareg  in  word_size  receiver parallel output.
- load  in  1  receiver pulse; RCV_datareg updates on this same edge.
- read_not_ready_out  in  1  receiver end-of-frame pulse.
- Error1  in  1  receiver overrun pulse (frame ended while not ready).
- Error2  in  1  receiver framing-error pulse (missing stop bit).
- read_not_ready_in  out  1  to receiver; 1 = host cannot take a word.
- host_data  out  word_size  FIFO head word.
- host_valid  out  1  FIFO non-empty.
- host_ready  in  1  host accepts head word when host_valid=1.
- fifo_count  out  FIFO_ADDR_BITS+1  entries currently stored (0..FIFO_DEPTH).
- overrun_count  out  ERR_CNT_BITS  Error1 events, saturating.
- framing_count  out  ERR_CNT_BITS  Error2 events, saturating.

Behaviour:
- Reset (rst_b=1, asynchronous):
  - state=WAIT; FIFO empty; fifo_count=0; host_valid=0; host_data=0.
  - overrun_count=0; framing_count=0; read_not_ready_in=1.
- FSM states:
  - WAIT: load=1 -> CAPTURE. Otherwise stay.
  - CAPTURE (exactly 1 cycle): RCV_datareg now holds the new word. Write it to the FIFO tail at the end of this cycle, then -> WAIT.
- Capture latency: word appears at host_data/host_valid 2 edges after the load pulse if the FIFO was empty.
- Slot reservation: occupancy = fifo_count + (state==CAPTURE).
- read_not_ready_in is registered. Next value = ~rx_enable OR (occupancy_next >= FIFO_DEPTH), computed from post-edge occupancy. A word is therefore never offered when no slot exists.
- Pop: host_valid & host_ready pops the head at the edge.
  - Simultaneous push and pop: fifo_count unchanged; the head advances to the next entry (or to the pushed word if only one was stored).
  - host_ready while host_valid=0: ignored.
- Pointers: FIFO_ADDR_BITS wide, wrap modulo FIFO_DEPTH. fifo_count stays within 0..FIFO_DEPTH.
- load arriving while FIFO full cannot occur, because read_not_ready_in is held high. If it does occur, the word is discarded, fifo_count is unchanged and no pointer moves.
- Error counters:
  - Error1 pulse -> overrun_count+1; Error2 pulse -> framing_count+1.
  - Both saturate at all-ones.
  - Counting is independent of rx_enable.
  - clr_counts has priority over a same-cycle increment (result 0).
- flush:
  - Priority over push and pop in the same cycle.
  - FIFO emptied; pointers=0; fifo_count=0; host_valid=0.
  - A CAPTURE in progress writes nothing and returns to WAIT.
  - read_not_ready_in next = ~rx_enable.
- rx_enable deassert mid-capture: the pending CAPTURE still completes. Only the handshake output changes.
- host_data: reflects the FIFO head combinationally from storage. Value is don't-care when host_valid=0, but must be 0 after reset.

Test Plan:
- Reset then rx_enable=1; pulse load with RCV_datareg=8'hA5 -> host_valid=1 and host_data=8'hA5 two edges later; fifo_count=1. Then host_ready=1 for 1 cycle -> fifo_count=0, host_valid=0.
- Four loads (8'h11, 22, 33, 44) with host_ready=0 -> read_not_ready_in=1 after the 4th CAPTURE. Pop 1 -> read_not_ready_in=0 the next cycle. Read order is 11, 22, 33, 44.
- FIFO holding 2 words; load and host_ready=1 in the CAPTURE cycle -> fifo_count stays 2; order is preserved across pointer wrap.
- 300 Error1 pulses -> overrun_count=8'hFF. clr_counts together with an Error2 pulse -> framing_count=0.
- load pulse, then flush in the CAPTURE cycle with 3 words stored -> fifo_count=0, host_valid=0, nothing written.
- rx_enable=0 with FIFO empty -> read_not_ready_in=1 next edge. Assert rst_b mid-CAPTURE -> all outputs return to reset values immediately.
